// File: rtl/segment_decode_capture_pkg.sv
// Shared 7-segment glyph definitions used by the hex encoder and the capture decoder.
package segment_decode_capture_pkg;

    // Active-low glyphs, bit order [6:0] = g..a
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h27;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Result of decoding one glyph back to a hex digit
    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } seg_dec_t;

    // Decoder output for a pattern that is not one of the sixteen glyphs
    localparam seg_dec_t SEG_INVALID = 5'b0_0000;

    // Forward mapping used by the encoder side
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = SEG_0;
            4'h1: hex_to_seg = SEG_1;
            4'h2: hex_to_seg = SEG_2;
            4'h3: hex_to_seg = SEG_3;
            4'h4: hex_to_seg = SEG_4;
            4'h5: hex_to_seg = SEG_5;
            4'h6: hex_to_seg = SEG_6;
            4'h7: hex_to_seg = SEG_7;
            4'h8: hex_to_seg = SEG_8;
            4'h9: hex_to_seg = SEG_9;
            4'hA: hex_to_seg = SEG_A;
            4'hB: hex_to_seg = SEG_B;
            4'hC: hex_to_seg = SEG_C;
            4'hD: hex_to_seg = SEG_D;
            4'hE: hex_to_seg = SEG_E;
            default: hex_to_seg = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/segment_decode_capture_seg7_to_hex.sv
// Combinational inverse of the hex-to-7-segment encoder.
module seg7_to_hex
    import segment_decode_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    seg_dec_t dec;

    // Map each known glyph back to its hex value; anything else is flagged invalid
    always_comb begin
        dec = SEG_INVALID;
        case (seg)
            SEG_0: dec = {1'b1, 4'h0};
            SEG_1: dec = {1'b1, 4'h1};
            SEG_2: dec = {1'b1, 4'h2};
            SEG_3: dec = {1'b1, 4'h3};
            SEG_4: dec = {1'b1, 4'h4};
            SEG_5: dec = {1'b1, 4'h5};
            SEG_6: dec = {1'b1, 4'h6};
            SEG_7: dec = {1'b1, 4'h7};
            SEG_8: dec = {1'b1, 4'h8};
            SEG_9: dec = {1'b1, 4'h9};
            SEG_A: dec = {1'b1, 4'hA};
            SEG_B: dec = {1'b1, 4'hB};
            SEG_C: dec = {1'b1, 4'hC};
            SEG_D: dec = {1'b1, 4'hD};
            SEG_E: dec = {1'b1, 4'hE};
            SEG_F: dec = {1'b1, 4'hF};
            default: dec = SEG_INVALID;
        endcase
    end

    assign valid  = dec.valid;
    assign nibble = dec.nibble;

endmodule

// File: rtl/segment_decode_capture.sv
// Samples a scanned 7-segment bus, debounces each digit and assembles the displayed word.
module segment_decode_capture
    import segment_decode_capture_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  seg_in,
    input  logic [DIGITS-1:0]           dig_sel,
    output logic [4*DIGITS-1:0]         word_out,
    output logic                        word_valid,
    output logic                        pat_err,
    output logic [$clog2(DIGITS)-1:0]   err_digit
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 2);

    logic [6:0]          seg_q, prev_seg;
    logic [DIGITS-1:0]   sel_q, prev_sel;
    logic [CW-1:0]       cnt;
    logic                armed;
    logic [DIGITS-1:0]   mask;
    logic [4*DIGITS-1:0] slots;

    logic                sel_onehot;
    logic                stable;
    logic                capture;
    logic                complete;
    logic                dec_valid;
    logic [3:0]          dec_nibble;
    logic [IW-1:0]       sel_idx;
    logic [4*DIGITS-1:0] next_slots;

    // The decimal point carries no digit information and is dropped here
    logic unused_dp;
    assign unused_dp = seg_in[7];

    seg7_to_hex u_seg7_to_hex (
        .seg    (seg_q),
        .valid  (dec_valid),
        .nibble (dec_nibble)
    );

    // Stability test, digit index, capture decision and the slot image including this capture
    always_comb begin
        sel_onehot = $onehot(sel_q);
        stable     = sel_onehot && (seg_q == prev_seg) && (sel_q == prev_sel);
        capture    = stable && armed && (cnt == CNT_ARM);
        sel_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) begin
                sel_idx = IW'(i);
            end
        end
        next_slots = slots;
        next_slots[4*sel_idx +: 4] = dec_nibble;
        complete   = capture && dec_valid && ((mask | sel_q) == '1);
    end

    // Register the incoming sample and keep the previous one for comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= '0;
            sel_q    <= '0;
            prev_seg <= '0;
            prev_sel <= '0;
        end else begin
            seg_q    <= seg_in[6:0];
            sel_q    <= dig_sel;
            prev_seg <= seg_q;
            prev_sel <= sel_q;
        end
    end

    // Count identical one-hot samples; any change re-arms so each stable run captures once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (stable) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (capture) begin
                armed <= 1'b0;
            end
        end else begin
            cnt   <= '0;
            armed <= 1'b1;
        end
    end

    // Store captured digits, flag bad glyphs and publish the word once every digit is present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots      <= '0;
            mask       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            pat_err    <= 1'b0;
            err_digit  <= '0;
        end else begin
            word_valid <= 1'b0;
            pat_err    <= 1'b0;
            if (capture) begin
                if (dec_valid) begin
                    slots <= next_slots;
                    if (complete) begin
                        word_out   <= next_slots;
                        word_valid <= 1'b1;
                        mask       <= '0;
                    end else begin
                        mask <= mask | sel_q;
                    end
                end else begin
                    pat_err   <= 1'b1;
                    err_digit <= sel_idx;
                    mask      <= mask & ~sel_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_segment_decode_capture.sv
// Self-checking bench for segment_decode_capture with a cycle-level reference model.
module tb_segment_decode_capture;

    localparam int STABLE = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] word_out;
    logic        word_valid;
    logic        pat_err;
    logic [1:0]  err_digit;

    int total = 0;
    int bad   = 0;
    int vp    = 0;
    int ep    = 0;

    // Reference model state: glyph list, run length of identical samples, captured digits
    logic [6:0]  glyphs [16];
    logic [6:0]  m_last_seg;
    logic [3:0]  m_last_sel;
    int          m_run;
    logic [3:0]  m_have;
    logic [3:0]  m_nib [4];
    logic [15:0] exp_word;
    logic        exp_valid;
    logic        exp_err;
    logic [1:0]  exp_errdig;

    typedef struct {
        logic [6:0] seg;
        bit         ok;
        logic [3:0] nib;
    } glyph_vec_t;

    glyph_vec_t vecs [19];

    segment_decode_capture #(.DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .word_out   (word_out),
        .word_valid (word_valid),
        .pat_err    (pat_err),
        .err_digit  (err_digit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        int r = -1;
        for (int i = 0; i < 16; i++) begin
            if (glyphs[i] == s) r = i;
        end
        return r;
    endfunction

    task automatic modelReset();
        m_run      = 0;
        m_have     = '0;
        m_last_seg = '0;
        m_last_sel = '0;
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        exp_word   = '0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        exp_errdig = '0;
    endtask

    // A digit is taken when STABLE identical one-hot samples have been seen in a row
    task automatic modelSample(input logic [6:0] s, input logic [3:0] sel);
        int d;
        int n;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if ($countones(sel) != 1) m_run = 0;
        else if (m_run > 0 && s == m_last_seg && sel == m_last_sel) m_run++;
        else m_run = 1;
        m_last_seg = s;
        m_last_sel = sel;
        if (m_run == STABLE) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) d = i;
            n = lookup(s);
            if (n >= 0) begin
                m_nib[d]  = n[3:0];
                m_have[d] = 1'b1;
                if (m_have == 4'hF) begin
                    exp_word  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    exp_valid = 1'b1;
                    m_have    = '0;
                end
            end else begin
                exp_err    = 1'b1;
                exp_errdig = d[1:0];
                m_have[d]  = 1'b0;
            end
        end
    endtask

    // Drive one sample, clock it in and compare every output against the model
    task automatic applyStimulus(input logic [7:0] s, input logic [3:0] sel);
        seg_in  = s;
        dig_sel = sel;
        @(posedge clk);
        #1;
        checkOutput("word_out", word_out, exp_word);
        checkOutput("word_valid", {15'b0, word_valid}, {15'b0, exp_valid});
        checkOutput("pat_err", {15'b0, pat_err}, {15'b0, exp_err});
        checkOutput("err_digit", {14'b0, err_digit}, {14'b0, exp_errdig});
        if (word_valid) vp++;
        if (pat_err) ep++;
        modelSample(s[6:0], sel);
    endtask

    task automatic holdDigit(input int d, input logic [6:0] g, input int cycles, input bit toggle_dp);
        logic [3:0] sel;
        logic       dp;
        sel = 4'b0001 << d;
        for (int i = 0; i < cycles; i++) begin
            dp = toggle_dp ? i[0] : 1'b0;
            applyStimulus({dp, g}, sel);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(8'hFF, 4'b0000);
    endtask

    task automatic doReset();
        seg_in  = 8'($urandom);
        dig_sel = 4'($urandom);
        rst     = 1'b1;
        #1;
        checkOutput("rst_word_out", word_out, 16'h0000);
        checkOutput("rst_word_valid", {15'b0, word_valid}, 16'h0000);
        checkOutput("rst_pat_err", {15'b0, pat_err}, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
        vecs[0]  = '{7'h40, 1'b1, 4'h0};
        vecs[1]  = '{7'h79, 1'b1, 4'h1};
        vecs[2]  = '{7'h24, 1'b1, 4'h2};
        vecs[3]  = '{7'h30, 1'b1, 4'h3};
        vecs[4]  = '{7'h19, 1'b1, 4'h4};
        vecs[5]  = '{7'h12, 1'b1, 4'h5};
        vecs[6]  = '{7'h02, 1'b1, 4'h6};
        vecs[7]  = '{7'h78, 1'b1, 4'h7};
        vecs[8]  = '{7'h00, 1'b1, 4'h8};
        vecs[9]  = '{7'h10, 1'b1, 4'h9};
        vecs[10] = '{7'h08, 1'b1, 4'hA};
        vecs[11] = '{7'h03, 1'b1, 4'hB};
        vecs[12] = '{7'h27, 1'b1, 4'hC};
        vecs[13] = '{7'h21, 1'b1, 4'hD};
        vecs[14] = '{7'h06, 1'b1, 4'hE};
        vecs[15] = '{7'h0E, 1'b1, 4'hF};
        vecs[16] = '{7'h7F, 1'b0, 4'h0};
        vecs[17] = '{7'h01, 1'b0, 4'h0};
        vecs[18] = '{7'h3F, 1'b0, 4'h0};

        // Asynchronous reset with random inputs, before any clock edge
        rst     = 1'b0;
        seg_in  = 8'($urandom);
        dig_sel = 4'($urandom);
        #1;
        doReset();

        // Full scan of four glyphs
        vp = 0;
        holdDigit(0, 7'h30, 6, 1'b0);
        holdDigit(1, 7'h06, 6, 1'b0);
        holdDigit(2, 7'h40, 6, 1'b0);
        holdDigit(3, 7'h0E, 6, 1'b0);
        idle(2);
        checkOutput("scan_word", word_out, 16'hF0E3);
        checkOutput("scan_pulses", 16'(vp), 16'd1);

        // Digit 1 held one cycle too short, then a proper run completes the word
        vp = 0;
        holdDigit(0, 7'h79, 5, 1'b0);
        holdDigit(1, 7'h24, 3, 1'b0);
        holdDigit(2, 7'h30, 5, 1'b0);
        holdDigit(3, 7'h19, 5, 1'b0);
        idle(2);
        checkOutput("short_run_pulses", 16'(vp), 16'd0);
        holdDigit(1, 7'h24, 4, 1'b0);
        idle(2);
        checkOutput("short_run_word", word_out, 16'h4321);
        checkOutput("short_run_pulses2", 16'(vp), 16'd1);

        // Blank glyph on digit 2 for a long run
        vp = 0;
        ep = 0;
        holdDigit(0, 7'h12, 5, 1'b0);
        holdDigit(1, 7'h02, 5, 1'b0);
        holdDigit(2, 7'h7F, 8, 1'b0);
        holdDigit(3, 7'h78, 5, 1'b0);
        idle(2);
        checkOutput("blank_err_pulses", 16'(ep), 16'd1);
        checkOutput("blank_err_digit", {14'b0, err_digit}, 16'd2);
        checkOutput("blank_valid_pulses", 16'(vp), 16'd0);
        holdDigit(2, 7'h00, 5, 1'b0);
        idle(2);
        checkOutput("blank_recover_word", word_out, 16'h7865);
        checkOutput("blank_recover_pulses", 16'(vp), 16'd1);

        // Multi-hot strobe is ignored and keeps the digits already collected
        vp = 0;
        holdDigit(0, 7'h10, 5, 1'b0);
        holdDigit(1, 7'h08, 5, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus({1'b0, 7'h03}, 4'b0110);
        checkOutput("multihot_pulses", 16'(vp), 16'd0);
        holdDigit(2, 7'h03, 5, 1'b0);
        holdDigit(3, 7'h27, 5, 1'b0);
        idle(2);
        checkOutput("multihot_word", word_out, 16'hCBA9);
        checkOutput("multihot_pulses2", 16'(vp), 16'd1);

        // Toggling DP while glyphs are held
        vp = 0;
        holdDigit(0, 7'h21, 5, 1'b1);
        holdDigit(1, 7'h06, 5, 1'b1);
        holdDigit(2, 7'h0E, 5, 1'b1);
        holdDigit(3, 7'h40, 5, 1'b1);
        idle(2);
        checkOutput("dp_word", word_out, 16'h0FED);
        checkOutput("dp_pulses", 16'(vp), 16'd1);

        // Reset in the middle of a scan discards the partial word
        holdDigit(0, 7'h79, 5, 1'b0);
        holdDigit(1, 7'h24, 5, 1'b0);
        doReset();
        vp = 0;
        holdDigit(2, 7'h30, 5, 1'b0);
        holdDigit(3, 7'h19, 5, 1'b0);
        idle(2);
        checkOutput("midrst_pulses", 16'(vp), 16'd0);
        checkOutput("midrst_word", word_out, 16'h0000);
        holdDigit(0, 7'h79, 5, 1'b0);
        holdDigit(1, 7'h24, 5, 1'b0);
        idle(2);
        checkOutput("midrst_word2", word_out, 16'h4321);
        checkOutput("midrst_pulses2", 16'(vp), 16'd1);

        // Every glyph in the table plus some non-glyphs, shown on all four digits
        doReset();
        for (int i = 0; i < 19; i++) begin
            glyph_vec_t v;
            v  = vecs[i];
            vp = 0;
            ep = 0;
            for (int d = 0; d < 4; d++) holdDigit(d, v.seg, 5, 1'b0);
            idle(2);
            checkOutput("table_valid_pulses", 16'(vp), v.ok ? 16'd1 : 16'd0);
            checkOutput("table_err_pulses", 16'(ep), v.ok ? 16'd0 : 16'd4);
            if (v.ok) checkOutput("table_word", word_out, {4{v.nib}});
            else checkOutput("table_err_digit", {14'b0, err_digit}, 16'd3);
        end

        // Randomized scans checked cycle by cycle against the model
        doReset();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 49) == 0) doReset();
            for (int d = 0; d < 4; d++) begin
                logic [3:0] sel;
                logic [6:0] g;
                int         hold;
                sel  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : (4'b0001 << d);
                g    = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyphs[$urandom_range(0, 15)];
                hold = $urandom_range(1, 7);
                for (int h = 0; h < hold; h++) applyStimulus({1'($urandom), g}, sel);
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
